// File: rtl/clm_sqrt.sv
// clm_sqrt: masked GF(2^8) Frobenius power (square root for k = 7) on a redundant 8+d bit encoding.
// Latency k+1 cycles from accept to o_out_valid; one refreshed squaring per RUN cycle.
// Backpressure: result held in DONE until i_out_ready; optional pow port under CLM_SQRT_POW_EN.

package clm_types_pkg;
  localparam int unsigned D = 2;
  typedef logic [8+D-1:0]          state_t;
  typedef logic [D-1:0]            red_poly_t;
  typedef logic [7+2*D-1:0][7:0]   mul_m_matrix_t;
endpackage

module clm_sqrt #(
  parameter int unsigned d = clm_types_pkg::D
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [8+d-1:0]           i_in_data,
`ifdef CLM_SQRT_POW_EN
  input  logic [2:0]               i_pow,
`endif
  input  logic [d-1:0]             i_rnd,
  output logic                     o_rnd_used,
  input  logic [7+2*d-1:0][7:0]    i_b_ext,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [8+d-1:0]           o_out_data
);

  localparam int unsigned W  = 8 + d;       // redundant state width
  localparam int unsigned PW = 15 + 2*d;    // width of the spread square
  localparam int unsigned VW = 7 + 2*d;     // reduction vector width {rnd, high part}

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [W-1:0]    r_acc;
  logic [2:0]      r_cnt;
  logic            w_accept;
  logic            w_last;
  logic            w_k_zero;
  logic [PW-1:0]   w_p;
  logic [VW-1:0]   w_v;
  logic [W-1:0]    w_sq;

`ifdef CLM_SQRT_POW_EN
  logic [2:0]      r_k;

  // Squaring count is captured at accept; k = 0 bypasses RUN entirely.
  assign w_k_zero = (i_pow == 3'd0);
  assign w_last   = (r_cnt == (r_k - 3'd1));
`else
  // Square-root only build: seven squarings, terminal count 6.
  assign w_k_zero = 1'b0;
  assign w_last   = (r_cnt == 3'd6);
`endif

  assign w_accept = i_in_valid & o_in_ready;

  // One refreshed squaring: spread bits, fold the high part plus rnd back through B_ext.
  always_comb begin
    w_p = '0;
    for (int i = 0; i < int'(W); i++) begin
      w_p[2*i] = r_acc[i];
    end
    w_v  = {i_rnd, w_p[PW-1:W]};
    w_sq = '0;
    for (int i = 0; i < 8; i++) begin
      w_sq[i] = w_p[i];
      for (int m = 0; m < int'(VW); m++) begin
        w_sq[i] = w_sq[i] ^ (w_v[m] & i_b_ext[m][i]);
      end
    end
    for (int j = 0; j < int'(d); j++) begin
      w_sq[8+j] = w_p[8+j] ^ i_rnd[j];
    end
  end

  // Next-state and handshake outputs; an accept in DONE overrides the return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    o_rnd_used  = 1'b0;
    o_out_data  = '0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
      end
      S_RUN: begin
        o_rnd_used = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        o_out_data  = r_acc;
        o_in_ready  = i_out_ready;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_accept) begin
      w_state_nxt = w_k_zero ? S_DONE : S_RUN;
    end
  end

  // State, accumulator and squaring counter; acc only moves on accept or in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= 3'd0;
`ifdef CLM_SQRT_POW_EN
      r_k     <= 3'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc <= i_in_data;
        r_cnt <= 3'd0;
`ifdef CLM_SQRT_POW_EN
        r_k   <= i_pow;
`endif
      end else if (r_state == S_RUN) begin
        r_acc <= w_sq;
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_clm_sqrt.sv
// Directed and random checks for clm_sqrt: decoded field results, latency, rnd usage,
// back-to-back flow, backpressure hold and mid-run reset.
// Optional pow vectors are compiled in when CLM_SQRT_POW_EN is defined.

module tb_clm_sqrt;
  localparam int D  = 2;
  localparam int W  = 8 + D;
  localparam int HW = 7 + D;
  localparam int VW = 7 + 2*D;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_in_valid = 1'b0;
  logic                 o_in_ready;
  logic [W-1:0]         i_in_data = '0;
  logic [D-1:0]         i_rnd = '0;
  logic                 o_rnd_used;
  logic [VW-1:0][7:0]   b_ext;
  logic                 o_out_valid;
  logic                 i_out_ready = 1'b1;
  logic [W-1:0]         o_out_data;
`ifdef CLM_SQRT_POW_EN
  logic [2:0]           i_pow = 3'd7;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0] din;
    int           k;
    bit           rnd_rand;
    logic [7:0]   exp_dec;
  } vec_t;

  vec_t vq[$];

  clm_sqrt #(.d(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
`ifdef CLM_SQRT_POW_EN
    .i_pow       (i_pow),
`endif
    .i_rnd       (i_rnd),
    .o_rnd_used  (o_rnd_used),
    .i_b_ext     (b_ext),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_data  (o_out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // x^n mod the AES polynomial
  function automatic logic [7:0] xpow(input int n);
    logic [8:0] t;
    t = 9'h001;
    for (int i = 0; i < n; i++) begin
      t = t << 1;
      if (t[8]) t = t ^ 9'h11B;
    end
    return t[7:0];
  endfunction

  function automatic logic [7:0] decode(input logic [W-1:0] a);
    logic [7:0] r;
    r = a[7:0];
    for (int j = 0; j < D; j++) if (a[8+j]) r = r ^ xpow(8 + j);
    return r;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // Bit-exact refreshed squaring step
  function automatic logic [W-1:0] sq_model(input logic [W-1:0] a, input logic [D-1:0] r);
    logic [2*W-2:0] p;
    logic [VW-1:0]  v;
    logic [W-1:0]   o;
    p = '0;
    for (int i = 0; i < W; i++) p[2*i] = a[i];
    v = {r, p[2*W-2:W]};
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[i] = p[i];
      for (int m = 0; m < VW; m++) o[i] = o[i] ^ (v[m] & b_ext[m][i]);
    end
    for (int j = 0; j < D; j++) o[8+j] = p[8+j] ^ r[j];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  // Offer one element, track rnd consumption in the model, return result and timing.
  task automatic run_one(input logic [W-1:0] din, input bit rr,
                         output logic [W-1:0] dout, output logic [W-1:0] mdl,
                         output int lat, output int nused);
    bit got;
    got = 1'b0; lat = 0; nused = 0; dout = '0; mdl = din;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data  = din;
    i_rnd      = rr ? D'($urandom) : '0;
    for (int c = 0; c < 20 && !o_in_ready; c++) @(negedge clk);
    if (!o_in_ready) timeout("in_ready");
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    i_in_data  = W'($urandom);
    if (rr) i_rnd = D'($urandom);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      if (o_out_valid) begin
        got  = 1'b1;
        dout = o_out_data;
        break;
      end
      if (o_rnd_used) begin
        nused++;
        mdl = sq_model(mdl, i_rnd);
      end
      @(posedge clk);
      #1;
      if (rr) i_rnd = D'($urandom);
    end
    if (!got) timeout("out_valid");
  endtask

  initial begin
    logic [W-1:0] dout;
    logic [W-1:0] mdl;
    logic [W-1:0] hold;
    logic [W-1:0] seq [4];
    logic [7:0]   sexp [4];
    int lat, nused, idx, nres, last_t, idle_rdy, nov;
    bit acc;

    // Rows 0..HW-1 reduce x^(W+m); top D rows cancel rnd injected at x^(8+j).
    for (int m = 0; m < HW; m++) b_ext[m] = xpow(W + m);
    for (int j = 0; j < D; j++) b_ext[HW+j] = xpow(8 + j);

    vq.push_back('{10'h001, 7, 1'b0, 8'h01});
    vq.push_back('{10'h000, 7, 1'b0, 8'h00});
    vq.push_back('{10'h004, 7, 1'b0, 8'h02});
    vq.push_back('{10'h010, 7, 1'b1, 8'h04});
    vq.push_back('{10'h040, 7, 1'b1, 8'h08});
    vq.push_back('{10'h11B, 7, 1'b1, 8'h00});
    vq.push_back('{10'h100, 7, 1'b1, 8'h10});
    vq.push_back('{10'h01B, 7, 1'b0, 8'h10});
    vq.push_back('{10'h11F, 7, 1'b1, 8'h02});
`ifdef CLM_SQRT_POW_EN
    vq.push_back('{10'h002, 4, 1'b0, 8'h5E});
    vq.push_back('{10'h002, 1, 1'b0, 8'h04});
    vq.push_back('{10'h2A5, 0, 1'b1, 8'h93});
`endif

    // Reset state
    #12;
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_rnd_used", o_rnd_used, 0);
    chk("rst_out_data", o_out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vq[i]) begin
`ifdef CLM_SQRT_POW_EN
      i_pow = vq[i].k[2:0];
`endif
      run_one(vq[i].din, vq[i].rnd_rand, dout, mdl, lat, nused);
      chk($sformatf("v%0d_dec", i), decode(dout), vq[i].exp_dec);
      chk($sformatf("v%0d_lat", i), lat, vq[i].k + 1);
      chk($sformatf("v%0d_rnd_used", i), nused, vq[i].k);
      chk($sformatf("v%0d_exact", i), dout, mdl);
      if (vq[i].k == 0) chk($sformatf("v%0d_passthru", i), dout, vq[i].din);
    end
`ifdef CLM_SQRT_POW_EN
    i_pow = 3'd7;
`endif

    // Random square roots with fresh rnd each cycle
    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] din;
      logic [7:0]   dd;
      din = W'($urandom);
      run_one(din, 1'b1, dout, mdl, lat, nused);
      dd = decode(dout);
      chk($sformatf("rnd%0d_exact", n), dout, mdl);
      chk($sformatf("rnd%0d_square", n), gf_mul(dd, dd), decode(din));
    end

    // Back-to-back with in_valid and out_ready held high
    seq[0] = 10'h004; seq[1] = 10'h010; seq[2] = 10'h040; seq[3] = 10'h001;
    sexp[0] = 8'h02;  sexp[1] = 8'h04;  sexp[2] = 8'h08;  sexp[3] = 8'h01;
    @(negedge clk);
    i_out_ready = 1'b1;
    i_rnd       = '0;
    i_in_valid  = 1'b1;
    i_in_data   = seq[0];
    idx = 0; nres = 0; last_t = 0; idle_rdy = 0;
    for (int c = 0; c < 60 && nres < 4; c++) begin
      if (c > 0) @(negedge clk);
      acc = o_in_ready && i_in_valid;
      if (o_in_ready && !o_out_valid) idle_rdy++;
      if (o_out_valid) begin
        chk($sformatf("b2b%0d_dec", nres), decode(o_out_data), sexp[nres]);
        if (nres > 0) chk($sformatf("b2b%0d_gap", nres), c - last_t, 8);
        last_t = c;
        nres++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) i_in_data = seq[idx];
        else i_in_valid = 1'b0;
      end
    end
    chk("b2b_count", nres, 4);
    chk("b2b_ready_outside_done", idle_rdy, 1);
    nov = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_out_valid) nov++;
    end
    chk("b2b_no_duplicate", nov, 0);

    // Backpressure: result held in DONE while out_ready is low
    @(negedge clk);
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = 10'h010;
    @(posedge clk);
    #1;
    i_in_data = 10'h040;
    for (int c = 0; c < 20 && !o_out_valid; c++) @(negedge clk);
    if (!o_out_valid) timeout("bp_out_valid");
    hold = o_out_data;
    chk("bp_dec", decode(hold), 8'h04);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_data", c), o_out_data, hold);
      chk($sformatf("bp%0d_valid", c), o_out_valid, 1);
      chk($sformatf("bp%0d_in_ready", c), o_in_ready, 0);
      chk($sformatf("bp%0d_rnd_used", c), o_rnd_used, 0);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", o_out_valid, 0);
    chk("bp_release_in_ready", o_in_ready, 1);

    // Reset pulsed while cnt = 3 in RUN
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data  = 10'h004;
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    for (int c = 0; c < 4; c++) @(negedge clk);
    chk("rr_running", o_rnd_used, 1);
    rst_n = 1'b0;
    #1;
    chk("rr_in_ready", o_in_ready, 1);
    chk("rr_out_valid", o_out_valid, 0);
    chk("rr_rnd_used", o_rnd_used, 0);
    chk("rr_out_data", o_out_data, 0);
    @(negedge clk);
    chk("rr_next_in_ready", o_in_ready, 1);
    chk("rr_next_out_valid", o_out_valid, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nov = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_out_valid) nov++;
    end
    chk("rr_no_emit", nov, 0);
    chk("rr_idle_ready", o_in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
